// File: rtl/register_ownership_manager.sv
// register_ownership_manager
//
// Tracks, for every architectural register, which processor core holds its
// newest value, and builds the renewed register file by muxing each register
// from its owning core. A core arms an ownership update with renew_req and a
// register number; the update commits on that core's next idle rising edge.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   core_registers      flattened register files, core c reg r at
//                       (c*REGISTER_AMOUNT+r)*REGISTER_WIDTH
//   core_idle           per-core idle level (rising edge triggers commit)
//   renew_req           per-core request to arm an ownership update
//   renew_reg_num       per-core target register number
//   renew_cancel        per-core abandon of an armed request
//   renew_ack/err       1-cycle accept / reject pulses
//   armed               core is waiting for its idle rising edge
//   commit_conflict     1-cycle pulse: commit lost to a lower-index core
//   main_program_state  1 = source from owner table, 0 = all from MAIN_CORE
//   fixed_register      value always used for FIXED_REG_IDX
//   owner_table         current owner per register
//   registers_renew     renewed register file
module register_ownership_manager #(
  parameter int NUM_CORES       = 2,
  parameter int REGISTER_AMOUNT = 32,
  parameter int REGISTER_WIDTH  = 64,
  parameter int FIXED_REG_IDX   = 1,
  parameter int MAIN_CORE       = 0,
  parameter int CORE_ID_WIDTH   = $clog2(NUM_CORES),
  parameter int REG_CTN_WIDTH   = $clog2(REGISTER_AMOUNT)
) (
  input  logic                                                 clk,
  input  logic                                                 rst_n,
  input  logic [NUM_CORES*REGISTER_AMOUNT*REGISTER_WIDTH-1:0]  core_registers,
  input  logic [NUM_CORES-1:0]                                 core_idle,
  input  logic [NUM_CORES-1:0]                                 renew_req,
  input  logic [NUM_CORES*REG_CTN_WIDTH-1:0]                   renew_reg_num,
  input  logic [NUM_CORES-1:0]                                 renew_cancel,
  output logic [NUM_CORES-1:0]                                 renew_ack,
  output logic [NUM_CORES-1:0]                                 renew_err,
  output logic [NUM_CORES-1:0]                                 armed,
  output logic [NUM_CORES-1:0]                                 commit_conflict,
  input  logic                                                 main_program_state,
  input  logic [REGISTER_WIDTH-1:0]                            fixed_register,
  output logic [REGISTER_AMOUNT*CORE_ID_WIDTH-1:0]             owner_table,
  output logic [REGISTER_AMOUNT*REGISTER_WIDTH-1:0]            registers_renew
);

  typedef enum logic {S_IDLE = 1'b0, S_ARMED = 1'b1} state_t;

  state_t                   state   [NUM_CORES];
  logic [REG_CTN_WIDTH-1:0] latched [NUM_CORES];
  logic [CORE_ID_WIDTH-1:0] owner   [REGISTER_AMOUNT];
  logic [NUM_CORES-1:0]     idle_q;
  logic [NUM_CORES-1:0]     rise;
  logic [NUM_CORES-1:0]     legal;
  logic [NUM_CORES-1:0]     commit;
  logic [NUM_CORES-1:0]     lost;

  always_comb begin
    rise   = core_idle & ~idle_q;
    legal  = '0;
    commit = '0;
    lost   = '0;
    armed  = '0;
    for (int c = 0; c < NUM_CORES; c++) begin
      legal[c]  = (int'(renew_reg_num[c*REG_CTN_WIDTH +: REG_CTN_WIDTH]) < REGISTER_AMOUNT) &&
                  (int'(renew_reg_num[c*REG_CTN_WIDTH +: REG_CTN_WIDTH]) != FIXED_REG_IDX);
      armed[c]  = (state[c] == S_ARMED);
      // Cancel beats a same-cycle rise.
      commit[c] = armed[c] & ~renew_cancel[c] & rise[c];
    end
    // A commit loses if any lower-index core commits the same register.
    for (int c = 1; c < NUM_CORES; c++) begin
      for (int k = 0; k < c; k++) begin
        if (commit[c] && commit[k] && (latched[k] == latched[c])) lost[c] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // History starts high so a core already idle at release makes no edge.
      idle_q          <= '1;
      renew_ack       <= '0;
      renew_err       <= '0;
      commit_conflict <= '0;
      for (int c = 0; c < NUM_CORES; c++) state[c] <= S_IDLE;
      for (int r = 0; r < REGISTER_AMOUNT; r++) owner[r] <= CORE_ID_WIDTH'(MAIN_CORE);
    end else begin
      idle_q          <= core_idle;
      renew_ack       <= '0;
      renew_err       <= '0;
      commit_conflict <= lost;
      for (int c = 0; c < NUM_CORES; c++) begin
        case (state[c])
          S_IDLE: begin
            if (renew_req[c]) begin
              if (legal[c]) begin
                state[c]     <= S_ARMED;
                renew_ack[c] <= 1'b1;
              end else begin
                renew_err[c] <= 1'b1;
              end
            end
          end
          S_ARMED: begin
            if (renew_cancel[c] || rise[c]) state[c] <= S_IDLE;
          end
          default: state[c] <= S_IDLE;
        endcase
      end
      // Highest index written first so the lowest committing core's write lands last.
      for (int c = NUM_CORES - 1; c >= 0; c--) begin
        if (commit[c]) owner[latched[c]] <= CORE_ID_WIDTH'(c);
      end
    end
  end

  // Register number is data; it is only meaningful while ARMED.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CORES; c++) begin
      if ((state[c] == S_IDLE) && renew_req[c] && legal[c])
        latched[c] <= renew_reg_num[c*REG_CTN_WIDTH +: REG_CTN_WIDTH];
    end
  end

  always_comb begin
    owner_table = '0;
    for (int r = 0; r < REGISTER_AMOUNT; r++)
      owner_table[r*CORE_ID_WIDTH +: CORE_ID_WIDTH] = owner[r];
  end

  always_comb begin
    int src;
    src             = MAIN_CORE;
    registers_renew = '0;
    for (int r = 0; r < REGISTER_AMOUNT; r++) begin
      if (r == FIXED_REG_IDX) begin
        registers_renew[r*REGISTER_WIDTH +: REGISTER_WIDTH] = fixed_register;
      end else begin
        src = main_program_state ? int'(owner[r]) : MAIN_CORE;
        registers_renew[r*REGISTER_WIDTH +: REGISTER_WIDTH] =
          core_registers[(src*REGISTER_AMOUNT + r)*REGISTER_WIDTH +: REGISTER_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_register_ownership_manager.sv
// Testbench for register_ownership_manager: directed scenarios followed by
// randomized traffic, checked against a behavioural model of owners and
// per-core request state.
module tb_register_ownership_manager;

  localparam int NC = 4;
  localparam int RA = 24;
  localparam int W  = 64;
  localparam int RW = $clog2(RA);
  localparam int CW = $clog2(NC);
  localparam int FIX = 1;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NC*RA*W-1:0]   core_registers;
  logic [NC-1:0]        core_idle, renew_req, renew_cancel;
  logic [NC*RW-1:0]     renew_reg_num;
  logic [NC-1:0]        renew_ack, renew_err, armed, commit_conflict;
  logic                 main_program_state;
  logic [W-1:0]         fixed_register;
  logic [RA*CW-1:0]     owner_table;
  logic [RA*W-1:0]      registers_renew;

  register_ownership_manager #(
    .NUM_CORES(NC), .REGISTER_AMOUNT(RA), .REGISTER_WIDTH(W),
    .FIXED_REG_IDX(FIX), .MAIN_CORE(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .core_registers(core_registers),
    .core_idle(core_idle), .renew_req(renew_req), .renew_reg_num(renew_reg_num),
    .renew_cancel(renew_cancel), .renew_ack(renew_ack), .renew_err(renew_err),
    .armed(armed), .commit_conflict(commit_conflict),
    .main_program_state(main_program_state), .fixed_register(fixed_register),
    .owner_table(owner_table), .registers_renew(registers_renew)
  );

  always #5 clk = ~clk;

  // Reference data and model state
  logic [W-1:0]  creg [NC][RA];
  bit            m_armed [NC];
  int            m_reg   [NC];
  int            m_owner [RA];
  bit [NC-1:0]   m_prev;
  bit [NC-1:0]   e_ack, e_err, e_conf;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pack_regs();
    for (int c = 0; c < NC; c++)
      for (int r = 0; r < RA; r++)
        core_registers[(c*RA + r)*W +: W] = creg[c][r];
  endtask

  task automatic set_num(input int c, input int v);
    renew_reg_num[c*RW +: RW] = RW'(v);
  endtask

  task automatic model_reset();
    for (int r = 0; r < RA; r++) m_owner[r] = 0;
    for (int c = 0; c < NC; c++) begin
      m_armed[c] = 1'b0;
      m_reg[c]   = 0;
    end
    m_prev = '1;
    e_ack  = '0;
    e_err  = '0;
    e_conf = '0;
  endtask

  task automatic check_all();
    logic [NC-1:0] exp_armed;
    logic [W-1:0]  exp_val;
    for (int c = 0; c < NC; c++) exp_armed[c] = m_armed[c];
    chk("renew_ack", W'(renew_ack), W'(e_ack));
    chk("renew_err", W'(renew_err), W'(e_err));
    chk("commit_conflict", W'(commit_conflict), W'(e_conf));
    chk("armed", W'(armed), W'(exp_armed));
    for (int r = 0; r < RA; r++)
      chk($sformatf("owner[%0d]", r), W'(owner_table[r*CW +: CW]), W'(m_owner[r]));
    for (int r = 0; r < RA; r++) begin
      if (r == FIX)                exp_val = fixed_register;
      else if (main_program_state) exp_val = creg[m_owner[r]][r];
      else                         exp_val = creg[0][r];
      chk($sformatf("renew[%0d]", r), registers_renew[r*W +: W], exp_val);
    end
  endtask

  // Advance one clock: model evaluates the current inputs, DUT clocks, compare.
  task automatic cycle();
    bit [NC-1:0] rise;
    bit          commit [NC];
    int          claimed [RA];
    int          v;
    rise   = core_idle & ~m_prev;
    e_ack  = '0;
    e_err  = '0;
    e_conf = '0;
    for (int r = 0; r < RA; r++) claimed[r] = -1;
    for (int c = 0; c < NC; c++) begin
      commit[c] = 1'b0;
      if (!m_armed[c]) begin
        if (renew_req[c]) begin
          v = int'(renew_reg_num[c*RW +: RW]);
          if (v < RA && v != FIX) begin
            e_ack[c]   = 1'b1;
            m_armed[c] = 1'b1;
            m_reg[c]   = v;
          end else begin
            e_err[c] = 1'b1;
          end
        end
      end else if (renew_cancel[c]) begin
        m_armed[c] = 1'b0;
      end else if (rise[c]) begin
        commit[c]  = 1'b1;
        m_armed[c] = 1'b0;
      end
    end
    // Lowest core index claims a register first; later claimants lose.
    for (int c = 0; c < NC; c++) begin
      if (commit[c]) begin
        if (claimed[m_reg[c]] >= 0) e_conf[c] = 1'b1;
        else begin
          claimed[m_reg[c]] = c;
          m_owner[m_reg[c]] = c;
        end
      end
    end
    m_prev = core_idle;
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic mid_reset();
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n              = 1'b0;
    core_idle          = '1;
    renew_req          = '0;
    renew_cancel       = '0;
    renew_reg_num      = '0;
    main_program_state = 1'b1;
    fixed_register     = 64'hDEAD_BEEF;
    for (int c = 0; c < NC; c++)
      for (int r = 0; r < RA; r++)
        creg[c][r] = {$urandom, $urandom};
    pack_regs();
    model_reset();

    // Reset state, then release with every core idle: no commits
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
    cycle();
    cycle();
    chk("renew5_core0", registers_renew[5*W +: W], creg[0][5]);

    // Core 2 arms reg 7 and commits on its idle rising edge
    renew_req[2] = 1'b1; set_num(2, 7);
    cycle();
    chk("ack_core2", W'(renew_ack[2]), 64'd1);
    renew_req = '0; core_idle[2] = 1'b0;
    cycle();
    core_idle[2] = 1'b1;
    cycle();
    chk("owner7_core2", W'(owner_table[7*CW +: CW]), 64'd2);
    main_program_state = 1'b1; #1;
    chk("renew7_mps1", registers_renew[7*W +: W], creg[2][7]);
    main_program_state = 1'b0; #1;
    chk("renew7_mps0", registers_renew[7*W +: W], creg[0][7]);
    check_all();
    main_program_state = 1'b1;

    // Cores 1 and 3 commit reg 9 together: core 1 wins
    renew_req = 4'b1010; set_num(1, 9); set_num(3, 9);
    cycle();
    renew_req = '0; core_idle[1] = 1'b0; core_idle[3] = 1'b0;
    cycle();
    core_idle[1] = 1'b1; core_idle[3] = 1'b1;
    cycle();
    chk("owner9_core1", W'(owner_table[9*CW +: CW]), 64'd1);
    chk("conflict3", W'(commit_conflict), 64'b1000);
    cycle();

    // Fixed register number rejected; out-of-range number rejected
    renew_req[0] = 1'b1; set_num(0, FIX);
    cycle();
    chk("err_fixed", W'(renew_err), 64'b0001);
    chk("renew1_fixed", registers_renew[1*W +: W], 64'hDEAD_BEEF);
    set_num(0, 30);
    cycle();
    chk("err_range", W'(renew_err), 64'b0001);
    renew_req = '0;
    cycle();

    // Cancel beats a same-cycle rise
    renew_req[1] = 1'b1; set_num(1, 4);
    cycle();
    renew_req = '0; core_idle[1] = 1'b0;
    cycle();
    renew_cancel[1] = 1'b1; core_idle[1] = 1'b1;
    cycle();
    chk("owner4_cancel", W'(owner_table[4*CW +: CW]), 64'd0);
    renew_cancel = '0;
    cycle();

    // Reset while armed discards the request
    renew_req[1] = 1'b1; set_num(1, 5);
    cycle();
    renew_req = '0; core_idle[1] = 1'b0;
    cycle();
    mid_reset();
    chk("armed_after_rst", W'(armed), 64'd0);
    cycle();
    core_idle[1] = 1'b1;
    cycle();
    chk("owner5_after_rst", W'(owner_table[5*CW +: CW]), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < NC; c++) begin
        renew_req[c]    = ($urandom_range(0, 2) == 0);
        renew_cancel[c] = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 2) == 0) core_idle[c] = ~core_idle[c];
        if ($urandom_range(0, 1) == 0) set_num(c, $urandom_range(2, 4));
        else                           set_num(c, $urandom_range(0, 31));
      end
      main_program_state = ($urandom_range(0, 1) == 1);
      if (i == 200) begin
        for (int c = 0; c < NC; c++)
          for (int r = 0; r < RA; r++)
            creg[c][r] = {$urandom, $urandom};
        pack_regs();
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
